// File: rtl/hd44780_lcd_sequencer.sv
// hd44780_lcd_sequencer
// Drives an HD44780 character LCD in 4-bit write-only mode. After reset it
// runs the power-on init sequence, then sends one host byte at a time as two
// E-pulsed nybbles followed by that command's execution delay.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// PWR_WAIT  | power-on wait before the first init nybble
// INIT_NYB  | load the next lone init nybble (0x3,0x3,0x3,0x2)
// INIT_BYTE | load the next init byte (0x28,0x08,0x01,0x06,0x0C)
// NYB_SETUP | rs/data driven, E low (address setup)
// NYB_EHI   | E high
// NYB_ELO   | E low for the rest of the E cycle, rs/data held
// POST_WAIT | execution delay after the last nybble of a transfer
// IDLE      | initialized, o_ready=1, waiting for a host strobe
//
// Timing notes (edge k = k-th rising clock edge after the reference edge):
// - Every delay of N ticks is loaded as N-1 and counts down to 0.
// - lcd_e first goes high on edge DELAY_100MS+TICKS_TAS+1 after reset
//   release: the 100 ms wait, one INIT_NYB dispatch edge, then the setup.
// - Each init step costs one dispatch edge (INIT_NYB/INIT_BYTE) after its
//   predecessor's post-wait. Host bytes are dispatched straight from IDLE,
//   so o_ready is back exactly 1+2*(TAS+TCYCE)+post-wait cycles after the
//   accept edge.
// - Asserting RST_I drops lcd_e at once and restarts from PWR_WAIT.

module hd44780_lcd_sequencer #(
    parameter int TIMER_BITS  = 23,
    parameter int DELAY_100MS = 4800000,
    parameter int DELAY_4P1MS = 196800,
    parameter int DELAY_3MS   = 144000,
    parameter int DELAY_100US = 4800,
    parameter int DELAY_53US  = 2544,
    parameter int TICKS_TAS   = 3,
    parameter int TICKS_PWEH  = 22,
    parameter int TICKS_TCYCE = 48
) (
    input  logic       CLK_I,
    input  logic       RST_I,
    input  logic [7:0] i_byte,
    input  logic       i_rs,
    input  logic       i_strobe,
    output logic       o_ready,
    output logic       o_init_done,
    output logic       lcd_rs,
    output logic       lcd_e,
    output logic [3:0] lcd_data
);

    typedef enum logic [2:0] {
        PWR_WAIT,
        INIT_NYB,
        INIT_BYTE,
        NYB_SETUP,
        NYB_EHI,
        NYB_ELO,
        POST_WAIT,
        IDLE
    } state_t;

    localparam logic [TIMER_BITS-1:0] LD_100MS = TIMER_BITS'(DELAY_100MS - 1);
    localparam logic [TIMER_BITS-1:0] LD_4P1MS = TIMER_BITS'(DELAY_4P1MS - 1);
    localparam logic [TIMER_BITS-1:0] LD_3MS   = TIMER_BITS'(DELAY_3MS - 1);
    localparam logic [TIMER_BITS-1:0] LD_100US = TIMER_BITS'(DELAY_100US - 1);
    localparam logic [TIMER_BITS-1:0] LD_53US  = TIMER_BITS'(DELAY_53US - 1);
    localparam logic [TIMER_BITS-1:0] LD_TAS   = TIMER_BITS'(TICKS_TAS - 1);
    localparam logic [TIMER_BITS-1:0] LD_PWEH  = TIMER_BITS'(TICKS_PWEH - 1);
    localparam logic [TIMER_BITS-1:0] LD_ELO   = TIMER_BITS'(TICKS_TCYCE - TICKS_PWEH - 1);

    // Steps 0..3 are lone nybbles, 4..8 are full bytes.
    localparam logic [3:0] LAST_NYB_STEP  = 4'd3;
    localparam logic [3:0] LAST_INIT_STEP = 4'd8;

    state_t                r_state;
    logic [TIMER_BITS-1:0] r_cnt;
    logic [TIMER_BITS-1:0] r_wait;
    logic [3:0]            r_step;
    logic [3:0]            r_lo_nyb;
    logic                  r_last_nyb;
    logic                  r_ready;
    logic                  r_init_done;
    logic                  r_lcd_rs;
    logic                  r_lcd_e;
    logic [3:0]            r_lcd_data;
    logic                  w_cnt_zero;

    assign w_cnt_zero  = (r_cnt == '0);
    assign o_ready     = r_ready;
    assign o_init_done = r_init_done;
    assign lcd_rs      = r_lcd_rs;
    assign lcd_e       = r_lcd_e;
    assign lcd_data    = r_lcd_data;

    // Clear and home commands need the long execution delay.
    function automatic logic [TIMER_BITS-1:0] f_byte_wait(input logic rs, input logic [7:0] b);
        if (!rs && (b == 8'h01 || b == 8'h02 || b == 8'h03))
            return LD_3MS;
        return LD_53US;
    endfunction

    function automatic logic [3:0] f_init_nyb(input logic [3:0] step);
        return (step == LAST_NYB_STEP) ? 4'h2 : 4'h3;
    endfunction

    function automatic logic [TIMER_BITS-1:0] f_init_nyb_wait(input logic [3:0] step);
        case (step)
            4'd0:       return LD_4P1MS;
            4'd1, 4'd2: return LD_100US;
            default:    return LD_53US;
        endcase
    endfunction

    function automatic logic [7:0] f_init_byte(input logic [3:0] step);
        case (step)
            4'd4:    return 8'h28;
            4'd5:    return 8'h08;
            4'd6:    return 8'h01;
            4'd7:    return 8'h06;
            default: return 8'h0C;
        endcase
    endfunction

    // Sequencer FSM: init steps, nybble E-pulse timing, post-waits and host handshake.
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            r_state     <= PWR_WAIT;
            r_cnt       <= LD_100MS;
            r_wait      <= '0;
            r_step      <= '0;
            r_lo_nyb    <= '0;
            r_last_nyb  <= 1'b0;
            r_ready     <= 1'b0;
            r_init_done <= 1'b0;
            r_lcd_rs    <= 1'b0;
            r_lcd_e     <= 1'b0;
            r_lcd_data  <= '0;
        end else begin
            case (r_state)
                PWR_WAIT: begin
                    if (w_cnt_zero)
                        r_state <= INIT_NYB;
                    else
                        r_cnt <= r_cnt - 1'b1;
                end

                INIT_NYB: begin
                    r_lcd_rs   <= 1'b0;
                    r_lcd_data <= f_init_nyb(r_step);
                    r_last_nyb <= 1'b1;
                    r_wait     <= f_init_nyb_wait(r_step);
                    r_cnt      <= LD_TAS;
                    r_state    <= NYB_SETUP;
                end

                INIT_BYTE: begin
                    r_lcd_rs   <= 1'b0;
                    r_lcd_data <= f_init_byte(r_step)[7:4];
                    r_lo_nyb   <= f_init_byte(r_step)[3:0];
                    r_last_nyb <= 1'b0;
                    r_wait     <= f_byte_wait(1'b0, f_init_byte(r_step));
                    r_cnt      <= LD_TAS;
                    r_state    <= NYB_SETUP;
                end

                NYB_SETUP: begin
                    if (w_cnt_zero) begin
                        r_lcd_e <= 1'b1;
                        r_cnt   <= LD_PWEH;
                        r_state <= NYB_EHI;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end

                NYB_EHI: begin
                    if (w_cnt_zero) begin
                        r_lcd_e <= 1'b0;
                        r_cnt   <= LD_ELO;
                        r_state <= NYB_ELO;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end

                NYB_ELO: begin
                    if (!w_cnt_zero) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else if (!r_last_nyb) begin
                        r_lcd_data <= r_lo_nyb;
                        r_last_nyb <= 1'b1;
                        r_cnt      <= LD_TAS;
                        r_state    <= NYB_SETUP;
                    end else begin
                        r_cnt   <= r_wait;
                        r_state <= POST_WAIT;
                    end
                end

                POST_WAIT: begin
                    if (!w_cnt_zero) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else if (r_init_done || r_step == LAST_INIT_STEP) begin
                        r_init_done <= 1'b1;
                        r_ready     <= 1'b1;
                        r_state     <= IDLE;
                    end else begin
                        r_step  <= r_step + 1'b1;
                        r_state <= (r_step < LAST_NYB_STEP) ? INIT_NYB : INIT_BYTE;
                    end
                end

                IDLE: begin
                    if (i_strobe && r_ready) begin
                        r_ready    <= 1'b0;
                        r_lcd_rs   <= i_rs;
                        r_lcd_data <= i_byte[7:4];
                        r_lo_nyb   <= i_byte[3:0];
                        r_last_nyb <= 1'b0;
                        r_wait     <= f_byte_wait(i_rs, i_byte);
                        r_cnt      <= LD_TAS;
                        r_state    <= NYB_SETUP;
                    end
                end

                default: begin
                    r_lcd_e <= 1'b0;
                    r_cnt   <= LD_100MS;
                    r_state <= PWR_WAIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hd44780_lcd_sequencer.sv
// Bench for hd44780_lcd_sequencer: power-on init, host bytes, held strobe,
// reset in the middle of an E pulse and strobes ignored during init.
// Times are counted in rising clock edges; a register updated on edge k is
// sampled shortly after the following falling edge.

module tb_hd44780_lcd_sequencer;

    localparam int TAS   = 2;
    localparam int PWEH  = 3;
    localparam int TCYCE = 6;
    localparam int D100MS = 100;
    localparam int D4P1   = 40;
    localparam int D3MS   = 30;
    localparam int D100US = 10;
    localparam int D53    = 5;

    logic       CLK_I    = 1'b0;
    logic       RST_I    = 1'b0;
    logic [7:0] i_byte   = 8'h00;
    logic       i_rs     = 1'b0;
    logic       i_strobe = 1'b0;
    logic       o_ready;
    logic       o_init_done;
    logic       lcd_rs;
    logic       lcd_e;
    logic [3:0] lcd_data;

    int n_cmp  = 0;
    int n_fail = 0;
    int gcyc   = 0;

    hd44780_lcd_sequencer #(
        .TIMER_BITS (16),
        .DELAY_100MS(D100MS),
        .DELAY_4P1MS(D4P1),
        .DELAY_3MS  (D3MS),
        .DELAY_100US(D100US),
        .DELAY_53US (D53),
        .TICKS_TAS  (TAS),
        .TICKS_PWEH (PWEH),
        .TICKS_TCYCE(TCYCE)
    ) dut (
        .CLK_I      (CLK_I),
        .RST_I      (RST_I),
        .i_byte     (i_byte),
        .i_rs       (i_rs),
        .i_strobe   (i_strobe),
        .o_ready    (o_ready),
        .o_init_done(o_init_done),
        .lcd_rs     (lcd_rs),
        .lcd_e      (lcd_e),
        .lcd_data   (lcd_data)
    );

    always #5 CLK_I = ~CLK_I;

    always @(posedge CLK_I) gcyc <= gcyc + 1;

    // Pin monitor: logs E rises (with data/rs), E falls and o_ready rises.
    int         rise_t[$];
    logic [3:0] rise_d[$];
    logic       rise_rs[$];
    int         fall_t[$];
    int         rdy_t[$];
    logic       prev_e   = 1'b0;
    logic       prev_rdy = 1'b0;

    always @(negedge CLK_I) begin
        if (lcd_e && !prev_e) begin
            rise_t.push_back(gcyc);
            rise_d.push_back(lcd_data);
            rise_rs.push_back(lcd_rs);
        end
        if (!lcd_e && prev_e) fall_t.push_back(gcyc);
        if (o_ready && !prev_rdy) rdy_t.push_back(gcyc);
        prev_e   = lcd_e;
        prev_rdy = o_ready;
    end

    // Execution delay after a byte: clear/home commands are long.
    function automatic int exp_wait(input logic rs, input logic [7:0] b);
        return (!rs && b >= 8'h01 && b <= 8'h03) ? D3MS : D53;
    endfunction

    task automatic tick();
        @(negedge CLK_I);
        #1;
    endtask

    task automatic test_reset(output int base);
        #2 RST_I = 1'b1;
        #1;
        n_cmp++; if (o_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b expected 0", o_ready); end
        n_cmp++; if (o_init_done !== 1'b0) begin n_fail++; $display("FAIL reset_init_done: got %b expected 0", o_init_done); end
        n_cmp++; if (lcd_e !== 1'b0) begin n_fail++; $display("FAIL reset_e: got %b expected 0", lcd_e); end
        n_cmp++; if (lcd_rs !== 1'b0) begin n_fail++; $display("FAIL reset_rs: got %b expected 0", lcd_rs); end
        n_cmp++; if (lcd_data !== 4'h0) begin n_fail++; $display("FAIL reset_data: got %h expected 0", lcd_data); end
        repeat (3) tick();
        RST_I = 1'b0;
        base  = gcyc;
    endtask

    // Reset released just after edge 'base'. Optional random strobes while init runs.
    task automatic test_init_sequence(input int base, input bit noisy);
        int         exp_t[$];
        logic [3:0] exp_d[$];
        logic [7:0] ib[5];
        int t_end, r, ready_t, target, guard, n_rise, i0, f0, r0;
        ib = '{8'h28, 8'h08, 8'h01, 8'h06, 8'h0C};
        i0 = rise_t.size(); f0 = fall_t.size(); r0 = rdy_t.size();
        t_end = base + D100MS;
        for (int s = 0; s < 4; s++) begin
            r = t_end + 1 + TAS;
            exp_t.push_back(r);
            exp_d.push_back((s == 3) ? 4'h2 : 4'h3);
            t_end = r + TCYCE + ((s == 0) ? D4P1 : (s == 3) ? D53 : D100US);
        end
        for (int s = 0; s < 5; s++) begin
            r = t_end + 1 + TAS;
            exp_t.push_back(r);
            exp_d.push_back(ib[s][7:4]);
            r = r + TCYCE + TAS;
            exp_t.push_back(r);
            exp_d.push_back(ib[s][3:0]);
            t_end = r + TCYCE + exp_wait(1'b0, ib[s]);
        end
        ready_t = t_end;
        target  = ready_t + 6;
        guard   = 0;
        while (gcyc < target && guard < 3000) begin
            tick();
            guard++;
            if (noisy && gcyc < ready_t - 3) begin
                i_strobe = 1'($urandom_range(0, 1));
                i_byte   = 8'($urandom);
                i_rs     = 1'($urandom_range(0, 1));
            end else begin
                i_strobe = 1'b0;
            end
            if (gcyc == ready_t - 1) begin
                n_cmp++; if (o_init_done !== 1'b0) begin n_fail++; $display("FAIL init_done_early: got %b expected 0", o_init_done); end
            end
        end
        i_strobe = 1'b0;
        n_rise = rise_t.size() - i0;
        n_cmp++; if (n_rise !== 14) begin n_fail++; $display("FAIL init_pulse_count: got %0d expected 14", n_rise); end
        for (int k = 0; k < 14 && k < n_rise; k++) begin
            n_cmp++; if (rise_t[i0+k] !== exp_t[k]) begin n_fail++; $display("FAIL init_rise_time[%0d]: got %0d expected %0d", k, rise_t[i0+k] - base, exp_t[k] - base); end
            n_cmp++; if (rise_d[i0+k] !== exp_d[k]) begin n_fail++; $display("FAIL init_nybble[%0d]: got %h expected %h", k, rise_d[i0+k], exp_d[k]); end
            n_cmp++; if (rise_rs[i0+k] !== 1'b0) begin n_fail++; $display("FAIL init_rs[%0d]: got %b expected 0", k, rise_rs[i0+k]); end
            n_cmp++;
            if (f0 + k >= fall_t.size()) begin n_fail++; $display("FAIL init_width[%0d]: got no fall expected %0d", k, PWEH); end
            else if (fall_t[f0+k] - rise_t[i0+k] !== PWEH) begin n_fail++; $display("FAIL init_width[%0d]: got %0d expected %0d", k, fall_t[f0+k] - rise_t[i0+k], PWEH); end
        end
        n_cmp++;
        if (rdy_t.size() <= r0) begin n_fail++; $display("FAIL init_ready_time: got none expected %0d", ready_t - base); end
        else if (rdy_t[r0] !== ready_t) begin n_fail++; $display("FAIL init_ready_time: got %0d expected %0d", rdy_t[r0] - base, ready_t - base); end
        n_cmp++; if (o_ready !== 1'b1) begin n_fail++; $display("FAIL init_ready: got %b expected 1", o_ready); end
        n_cmp++; if (o_init_done !== 1'b1) begin n_fail++; $display("FAIL init_done: got %b expected 1", o_init_done); end
    endtask

    task automatic wait_ready(input string tag);
        int guard = 0;
        while (!o_ready && guard < 500) begin tick(); guard++; end
        n_cmp++; if (o_ready !== 1'b1) begin n_fail++; $display("FAIL %s_wait_ready: got %b expected 1", tag, o_ready); end
    endtask

    // One host byte: pin timing, nybble order and handshake latency.
    task automatic test_byte(input logic [7:0] b, input logic rs);
        int acc, exp_rdy, target, guard, n_rise, i0, f0, r0;
        wait_ready("byte");
        i0 = rise_t.size(); f0 = fall_t.size(); r0 = rdy_t.size();
        i_byte = b; i_rs = rs; i_strobe = 1'b1;
        acc = gcyc + 1;
        tick();
        i_strobe = 1'b0;
        n_cmp++; if (o_ready !== 1'b0) begin n_fail++; $display("FAIL byte_%h_ready_c1: got %b expected 0", b, o_ready); end
        n_cmp++; if (lcd_data !== b[7:4] || lcd_rs !== rs) begin n_fail++; $display("FAIL byte_%h_c1_pins: got data %h rs %b expected data %h rs %b", b, lcd_data, lcd_rs, b[7:4], rs); end
        // o_ready seen in cycle 1+2*(TAS+TCYCE)+wait is written on that minus one edge.
        exp_rdy = acc + (1 + 2 * (TAS + TCYCE) + exp_wait(rs, b)) - 1;
        target  = exp_rdy + 3;
        guard   = 0;
        while (gcyc < target && guard < 500) begin tick(); guard++; end
        n_rise = rise_t.size() - i0;
        n_cmp++; if (n_rise !== 2) begin n_fail++; $display("FAIL byte_%h_pulses: got %0d expected 2", b, n_rise); end
        if (n_rise >= 2) begin
            n_cmp++; if (rise_t[i0] !== acc + TAS) begin n_fail++; $display("FAIL byte_%h_rise_hi: got %0d expected %0d", b, rise_t[i0] - acc, TAS); end
            n_cmp++; if (rise_t[i0+1] - rise_t[i0] !== TCYCE + TAS) begin n_fail++; $display("FAIL byte_%h_rise_gap: got %0d expected %0d", b, rise_t[i0+1] - rise_t[i0], TCYCE + TAS); end
            n_cmp++; if (rise_d[i0] !== b[7:4] || rise_d[i0+1] !== b[3:0]) begin n_fail++; $display("FAIL byte_%h_nybbles: got %h,%h expected %h,%h", b, rise_d[i0], rise_d[i0+1], b[7:4], b[3:0]); end
            n_cmp++; if (rise_rs[i0] !== rs || rise_rs[i0+1] !== rs) begin n_fail++; $display("FAIL byte_%h_rs: got %b,%b expected %b", b, rise_rs[i0], rise_rs[i0+1], rs); end
            n_cmp++;
            if (f0 + 1 >= fall_t.size()) begin n_fail++; $display("FAIL byte_%h_width: got missing fall expected %0d", b, PWEH); end
            else if (fall_t[f0] - rise_t[i0] !== PWEH || fall_t[f0+1] - rise_t[i0+1] !== PWEH) begin
                n_fail++; $display("FAIL byte_%h_width: got %0d,%0d expected %0d", b, fall_t[f0] - rise_t[i0], fall_t[f0+1] - rise_t[i0+1], PWEH);
            end
        end
        n_cmp++;
        if (rdy_t.size() <= r0) begin n_fail++; $display("FAIL byte_%h_ready_time: got none expected %0d", b, exp_rdy - acc + 1); end
        else if (rdy_t[r0] !== exp_rdy) begin n_fail++; $display("FAIL byte_%h_ready_time: got %0d expected %0d", b, rdy_t[r0] - acc + 1, exp_rdy - acc + 1); end
    endtask

    task automatic test_host_bytes();
        logic [7:0] db[6];
        logic       dr[6];
        db = '{8'h41, 8'h01, 8'h01, 8'h02, 8'h03, 8'h0C};
        dr = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        for (int k = 0; k < 6; k++) test_byte(db[k], dr[k]);
        for (int k = 0; k < 8; k++) test_byte(8'($urandom), 1'($urandom_range(0, 1)));
    endtask

    // Strobe held high across two transfers, i_byte changed mid-transfer.
    task automatic test_back_to_back();
        logic [7:0] a, b;
        logic       ra, rb;
        int acc1, acc2, rdy1, rdy2, target, guard, n_rise, i0, r0;
        a = 8'($urandom); b = 8'($urandom);
        if (b == a) b = ~a;
        ra = 1'($urandom_range(0, 1)); rb = 1'($urandom_range(0, 1));
        wait_ready("b2b");
        i0 = rise_t.size(); r0 = rdy_t.size();
        i_byte = a; i_rs = ra; i_strobe = 1'b1;
        acc1 = gcyc + 1;
        tick();
        i_byte = b; i_rs = rb;
        rdy1 = acc1 + 2 * (TAS + TCYCE) + exp_wait(ra, a);
        acc2 = rdy1 + 1;
        rdy2 = acc2 + 2 * (TAS + TCYCE) + exp_wait(rb, b);
        guard = 0;
        while (gcyc < acc2 && guard < 500) begin tick(); guard++; end
        i_strobe = 1'b0;
        target = rdy2 + 10;
        guard  = 0;
        while (gcyc < target && guard < 500) begin tick(); guard++; end
        n_rise = rise_t.size() - i0;
        n_cmp++; if (n_rise !== 4) begin n_fail++; $display("FAIL b2b_pulses: got %0d expected 4", n_rise); end
        if (n_rise >= 4) begin
            n_cmp++;
            if (rise_d[i0] !== a[7:4] || rise_d[i0+1] !== a[3:0] || rise_d[i0+2] !== b[7:4] || rise_d[i0+3] !== b[3:0]) begin
                n_fail++; $display("FAIL b2b_nybbles: got %h%h %h%h expected %h %h", rise_d[i0], rise_d[i0+1], rise_d[i0+2], rise_d[i0+3], a, b);
            end
            n_cmp++; if (rise_rs[i0+1] !== ra || rise_rs[i0+2] !== rb) begin n_fail++; $display("FAIL b2b_rs: got %b,%b expected %b,%b", rise_rs[i0+1], rise_rs[i0+2], ra, rb); end
            n_cmp++; if (rise_t[i0+2] !== acc2 + TAS) begin n_fail++; $display("FAIL b2b_second_rise: got %0d expected %0d", rise_t[i0+2], acc2 + TAS); end
        end
        n_cmp++;
        if (rdy_t.size() - r0 !== 2) begin n_fail++; $display("FAIL b2b_ready_windows: got %0d expected 2", rdy_t.size() - r0); end
        else if (rdy_t[r0] !== rdy1 || rdy_t[r0+1] !== rdy2) begin n_fail++; $display("FAIL b2b_ready_times: got %0d,%0d expected %0d,%0d", rdy_t[r0], rdy_t[r0+1], rdy1, rdy2); end
    endtask

    // Reset landing in an E-high phase, then a full re-init with strobes thrown at it.
    task automatic test_reset_during_pulse();
        int guard, base;
        wait_ready("rst");
        i_byte = 8'hA5; i_rs = 1'b1; i_strobe = 1'b1;
        tick();
        i_strobe = 1'b0;
        guard = 0;
        while (!lcd_e && guard < 20) begin tick(); guard++; end
        n_cmp++; if (lcd_e !== 1'b1) begin n_fail++; $display("FAIL rst_find_pulse: got e=%b expected 1", lcd_e); end
        RST_I = 1'b1;
        #1;
        n_cmp++; if (lcd_e !== 1'b0) begin n_fail++; $display("FAIL rst_mid_e: got %b expected 0", lcd_e); end
        n_cmp++; if (lcd_rs !== 1'b0 || lcd_data !== 4'h0) begin n_fail++; $display("FAIL rst_mid_pins: got rs %b data %h expected 0 0", lcd_rs, lcd_data); end
        n_cmp++; if (o_ready !== 1'b0 || o_init_done !== 1'b0) begin n_fail++; $display("FAIL rst_mid_flags: got ready %b done %b expected 0 0", o_ready, o_init_done); end
        tick(); tick();
        RST_I = 1'b0;
        base  = gcyc;
        test_init_sequence(base, 1'b1);
    endtask

    initial begin
        int base;
        test_reset(base);
        test_init_sequence(base, 1'b0);
        test_host_bytes();
        test_back_to_back();
        test_reset_during_pulse();
        test_byte(8'h41, 1'b1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
